// File: rtl/iob_reg_pipe_if.sv
// Valid/ready handshake bundle for iob_reg_pipe: upstream (in_*) and downstream (out_*) sides.
// The slave modport is the pipeline's view. The master modport is the view of the logic around it.
interface iob_reg_pipe_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iob_reg_pipe.sv
// Elastic register pipeline of STAGES valid-tagged stages with flush and occupancy level.
// Define IOB_REG_PIPE_SKID_EN to add a one-entry skid register that makes in_ready a registered output.
module iob_reg_pipe #(
    parameter int                DATA_W  = 8,
    parameter int                STAGES  = 2,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                LEVEL_W = $clog2(STAGES + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    iob_reg_pipe_if.slave      bus,
    output logic [LEVEL_W-1:0] level
);

    logic [STAGES-1:0]  vld_q, vld_d;
    logic [STAGES-1:0]  adv;
    logic [DATA_W-1:0]  data_q [STAGES];
    logic [DATA_W-1:0]  data_d [STAGES];
    logic               src_vld;
    logic [DATA_W-1:0]  src_data;
    logic               in_fire, out_fire;
    logic [LEVEL_W-1:0] level_q, level_d;

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin
        logic carry;
        carry = !vld_q[STAGES-1] || bus.out_ready;
        adv[STAGES-1] = carry;
        for (int i = STAGES - 2; i >= 0; i--) begin
            carry  = !vld_q[i] || carry;
            adv[i] = carry;
        end
    end

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = vld_q[STAGES-1] && bus.out_ready;

`ifdef IOB_REG_PIPE_SKID_EN
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    assign bus.in_ready = !skid_vld_q && !flush;
    assign src_vld      = skid_vld_q || in_fire;
    assign src_data     = skid_vld_q ? skid_data_q : bus.in_data;

    always_comb begin
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (skid_vld_q && adv[0]) begin
            skid_vld_d = 1'b0;
        end
        if (in_fire && !adv[0]) begin
            skid_vld_d  = 1'b1;
            skid_data_d = bus.in_data;
        end
        if (flush) begin
            skid_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_vld_q  <= 1'b0;
            skid_data_q <= RST_VAL;
        end else begin
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    assign bus.in_ready = adv[0] && !flush;
    assign src_vld      = in_fire;
    assign src_data     = bus.in_data;
`endif

    // Stage loads; data only moves with a valid beat, and a flush leaves data in place.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (flush) begin
            vld_d = '0;
        end else begin
            if (adv[0]) begin
                vld_d[0] = src_vld;
                if (src_vld) begin
                    data_d[0] = src_data;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    vld_d[i] = vld_q[i-1];
                    if (vld_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                    end
                end
            end
        end
    end

    always_comb begin
        level_d = level_q + LEVEL_W'(in_fire) - LEVEL_W'(out_fire);
        if (flush) begin
            level_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            level_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= RST_VAL;
            end
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            level_q <= level_d;
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];
    assign level         = level_q;

endmodule

// File: tb/tb_iob_reg_pipe.sv
// Directed bench for iob_reg_pipe with DATA_W=8, STAGES=3, RST_VAL=8'hA5.
// Capacity expectations follow IOB_REG_PIPE_SKID_EN when it is defined for the build.
module tb_iob_reg_pipe;

    localparam int DATA_W = 8;
    localparam int STAGES = 3;
    localparam logic [7:0] RST_VAL = 8'hA5;
    localparam int LEVEL_W = $clog2(STAGES + 2);
`ifdef IOB_REG_PIPE_SKID_EN
    localparam int CAP = STAGES + 1;
`else
    localparam int CAP = STAGES;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [LEVEL_W-1:0] level;
    int vecs = 0;
    int errs = 0;

    iob_reg_pipe_if #(.DATA_W(DATA_W)) bus ();

    iob_reg_pipe #(
        .DATA_W (DATA_W),
        .STAGES (STAGES),
        .RST_VAL(RST_VAL)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus),
        .level(level)
    );

    always #5 clk = ~clk;

    // Occupancy must never leave 0..CAP.
    always @(negedge clk) begin
        if (rst === 1'b0 && int'(level) > CAP) begin
            $display("FAIL level_range: level=%0d above max %0d", level, CAP);
            errs++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h77;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        vecs++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); errs++; end
        vecs++; if (bus.out_data !== 8'hA5) begin $display("FAIL reset_out_data: got %0h expected a5", bus.out_data); errs++; end
        vecs++; if (level !== 3'd0) begin $display("FAIL reset_level: got %0d expected 0", level); errs++; end
        vecs++; if (bus.in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); errs++; end
        for (int c = 0; c < 5; c++) begin
            tick();
            vecs++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_no_beat: cycle %0d out_valid=%0b expected 0", c, bus.out_valid); errs++; end
        end
    endtask

    task automatic test_stream;
        do_reset();
        bus.out_ready = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            bus.in_valid = (j <= 16);
            bus.in_data = 8'(j);
            #1;
            if (j <= 16) begin
                vecs++; if (bus.in_ready !== 1'b1) begin $display("FAIL stream_in_ready: edge %0d got %0b expected 1", j, bus.in_ready); errs++; end
            end
            tick();
            vecs++;
            if (bus.out_valid !== ((j >= 3 && j <= 18) ? 1'b1 : 1'b0)) begin
                $display("FAIL stream_out_valid: edge %0d got %0b", j, bus.out_valid); errs++;
            end
            if (j >= 3 && j <= 18) begin
                vecs++; if (bus.out_data !== 8'(j - 2)) begin $display("FAIL stream_out_data: edge %0d got %0h expected %0h", j, bus.out_data, 8'(j - 2)); errs++; end
            end
            if (j >= 3 && j <= 16) begin
                vecs++; if (level !== 3'd3) begin $display("FAIL stream_level: edge %0d got %0d expected 3", j, level); errs++; end
            end
        end
        vecs++; if (level !== 3'd0) begin $display("FAIL stream_drained: level got %0d expected 0", level); errs++; end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        int nxt;
        int rcv;
        do_reset();
        nxt = 0;
        rcv = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(nxt + 1);
            #1;
            vecs++; if (bus.in_ready !== ((c < CAP) ? 1'b1 : 1'b0)) begin $display("FAIL bp_in_ready: cycle %0d got %0b", c, bus.in_ready); errs++; end
            if (c >= 3) begin
                vecs++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin $display("FAIL bp_stable: cycle %0d got v=%0b d=%0h expected v=1 d=01", c, bus.out_valid, bus.out_data); errs++; end
            end
            if (bus.in_ready === 1'b1) nxt++;
            tick();
        end
        vecs++; if (int'(level) !== CAP) begin $display("FAIL bp_level: got %0d expected %0d", level, CAP); errs++; end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            bus.in_valid = (nxt < 5);
            bus.in_data = 8'(nxt + 1);
            #1;
            if (bus.out_valid === 1'b1) begin
                vecs++; if (bus.out_data !== 8'(rcv + 1)) begin $display("FAIL bp_order: beat %0d got %0h expected %0h", rcv, bus.out_data, 8'(rcv + 1)); errs++; end
                rcv++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) nxt++;
            tick();
        end
        vecs++; if (rcv !== 5) begin $display("FAIL bp_count: got %0d beats expected 5", rcv); errs++; end
        vecs++; if (level !== 3'd0) begin $display("FAIL bp_final_level: got %0d expected 0", level); errs++; end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_full_pipe;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(8'h10 + c);
            tick();
        end
        vecs++; if (level !== 3'd3) begin $display("FAIL full_fill_level: got %0d expected 3", level); errs++; end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.in_data = 8'(8'h13 + c);
            #1;
            vecs++; if (bus.in_ready !== 1'b1) begin $display("FAIL full_in_ready: cycle %0d got %0b expected 1", c, bus.in_ready); errs++; end
            vecs++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h10 + c)) begin $display("FAIL full_out: cycle %0d got v=%0b d=%0h expected d=%0h", c, bus.out_valid, bus.out_data, 8'(8'h10 + c)); errs++; end
            tick();
            vecs++; if (level !== 3'd3) begin $display("FAIL full_level: cycle %0d got %0d expected 3", c, level); errs++; end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_flush;
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data = 8'h21;
        tick();
        bus.in_data = 8'h22;
        tick();
        vecs++; if (level !== 3'd2) begin $display("FAIL flush_pre_level: got %0d expected 2", level); errs++; end
        flush = 1'b1;
        bus.in_data = 8'hEE;
        #1;
        vecs++; if (bus.in_ready !== 1'b0) begin $display("FAIL flush_in_ready: got %0b expected 0", bus.in_ready); errs++; end
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        vecs++; if (bus.out_valid !== 1'b0) begin $display("FAIL flush_out_valid: got %0b expected 0", bus.out_valid); errs++; end
        vecs++; if (level !== 3'd0) begin $display("FAIL flush_level: got %0d expected 0", level); errs++; end
        vecs++; if (bus.in_ready !== 1'b1) begin $display("FAIL flush_ready_after: got %0b expected 1", bus.in_ready); errs++; end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            vecs++; if (bus.out_valid !== 1'b0) begin $display("FAIL flush_leak: cycle %0d out_valid=%0b data=%0h", c, bus.out_valid, bus.out_data); errs++; end
        end
        bus.in_valid = 1'b1;
        bus.in_data = 8'h33;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        vecs++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33) begin $display("FAIL flush_recover: got v=%0b d=%0h expected v=1 d=33", bus.out_valid, bus.out_data); errs++; end
    endtask

    task automatic test_rst_flush;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(8'h40 + c);
            tick();
        end
        vecs++; if (int'(level) !== CAP) begin $display("FAIL rf_full_level: got %0d expected %0d", level, CAP); errs++; end
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        vecs++; if (bus.out_data !== 8'hA5) begin $display("FAIL rf_out_data: got %0h expected a5", bus.out_data); errs++; end
        vecs++; if (bus.out_valid !== 1'b0) begin $display("FAIL rf_out_valid: got %0b expected 0", bus.out_valid); errs++; end
        vecs++; if (level !== 3'd0) begin $display("FAIL rf_level: got %0d expected 0", level); errs++; end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_pipe();
        test_flush();
        test_rst_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
